// File: rtl/spio_spinnaker_link_sync_filter.sv
// -----------------------------------------------------------------------------
// spio_spinnaker_link_sync_filter
//
// Brings SIZE asynchronous SpiNNaker-link wires into the CLK_IN domain.
// Each bit goes through a STAGES-deep synchroniser and then a glitch filter.
// The filter moves OUT[i] only after the synchronised bit has disagreed with
// OUT[i] for FILTER consecutive cycles. One-cycle RISE/FALL pulses are
// registered in the same cycle that OUT changes.
//
// Optional feature (macro SPIO_SYNC_GLITCH_CNT_EN):
//   This adds a saturating 8-bit counter per bit that counts rejected glitches,
//   and a synchronous clear input for those counters.
//
// Ports:
//   CLK_IN          in   1        clock, all logic on rising edge
//   RESET_IN        in   1        synchronous active-high reset
//   IN              in   SIZE     asynchronous inputs
//   OUT             out  SIZE     synchronised, filtered value
//   RISE_OUT        out  SIZE     1-cycle pulse when OUT[i] goes 0->1
//   FALL_OUT        out  SIZE     1-cycle pulse when OUT[i] goes 1->0
//   CHANGE_OUT      out  1        OR of all RISE_OUT/FALL_OUT bits
//   CLR_GLITCH_IN   in   1        (macro only) clears the glitch counters
//   GLITCH_CNT_OUT  out  8*SIZE   (macro only) bits [8i+7:8i] hold the count for bit i
// -----------------------------------------------------------------------------
module spio_spinnaker_link_sync_filter #(
    parameter int   SIZE    = 1,
    parameter int   STAGES  = 2,
    parameter int   FILTER  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic            CLK_IN,
    input  logic            RESET_IN,
    input  logic [SIZE-1:0] IN,
    output logic [SIZE-1:0] OUT,
    output logic [SIZE-1:0] RISE_OUT,
    output logic [SIZE-1:0] FALL_OUT,
    output logic            CHANGE_OUT
`ifdef SPIO_SYNC_GLITCH_CNT_EN
    ,
    input  logic              CLR_GLITCH_IN,
    output logic [8*SIZE-1:0] GLITCH_CNT_OUT
`endif
);

    localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

    logic [STAGES-1:0][SIZE-1:0] sync_q, sync_d;
    logic [SIZE-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]             out_q, out_d;
    logic [SIZE-1:0]             rise_q, rise_d;
    logic [SIZE-1:0]             fall_q, fall_d;
    logic [SIZE-1:0]             s_w;

`ifdef SPIO_SYNC_GLITCH_CNT_EN
    logic [SIZE-1:0]             glitch_hit;
    logic [SIZE-1:0][7:0]        gcnt_q, gcnt_d;
`endif

    // Synchroniser shift chain; the last stage is the filter's input.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = IN;
        for (int n = 1; n < STAGES; n++) begin
            sync_d[n] = sync_q[n-1];
        end
    end

    assign s_w = sync_q[STAGES-1];

    // Per-bit filter. The counter tracks how long S has disagreed with OUT.
    // Any agreement discards the partial count. That is how glitches are dropped.
    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
`ifdef SPIO_SYNC_GLITCH_CNT_EN
        glitch_hit = '0;
`endif
        for (int i = 0; i < SIZE; i++) begin
            if (s_w[i] == out_q[i]) begin
                cnt_d[i] = '0;
`ifdef SPIO_SYNC_GLITCH_CNT_EN
                glitch_hit[i] = (cnt_q[i] != '0);
`endif
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i]  = s_w[i];
                cnt_d[i]  = '0;
                rise_d[i] = s_w[i];
                fall_d[i] = ~s_w[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef SPIO_SYNC_GLITCH_CNT_EN
    // Saturating counters. A clear in the same cycle overrides an increment.
    always_comb begin
        gcnt_d = gcnt_q;
        for (int i = 0; i < SIZE; i++) begin
            if (CLR_GLITCH_IN) begin
                gcnt_d[i] = 8'd0;
            end else if (glitch_hit[i] && gcnt_q[i] != 8'hFF) begin
                gcnt_d[i] = gcnt_q[i] + 8'd1;
            end
        end
    end
`endif

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            sync_q <= {STAGES{{SIZE{RST_VAL}}}};
            out_q  <= {SIZE{RST_VAL}};
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
`ifdef SPIO_SYNC_GLITCH_CNT_EN
            gcnt_q <= '0;
`endif
        end else begin
            sync_q <= sync_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
`ifdef SPIO_SYNC_GLITCH_CNT_EN
            gcnt_q <= gcnt_d;
`endif
        end
    end

    assign OUT        = out_q;
    assign RISE_OUT   = rise_q;
    assign FALL_OUT   = fall_q;
    assign CHANGE_OUT = |{rise_q, fall_q};

`ifdef SPIO_SYNC_GLITCH_CNT_EN
    assign GLITCH_CNT_OUT = gcnt_q;
`endif

endmodule

// File: tb/tb_spio_spinnaker_link_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_spio_spinnaker_link_sync_filter
//
// Three 4-bit instances share the clock, reset and inputs:
//   dut0: STAGES=2, FILTER=4, RST_VAL=0
//   dut1: STAGES=3, FILTER=1, RST_VAL=0
//   dut2: STAGES=2, FILTER=3, RST_VAL=1
// Each instance has a behavioural model.
//   The synchroniser is a delay line of STAGES samples.
//   OUT flips when the last FILTER synchronised samples all disagree with it.
//   A glitch is a disagreement that ends without a flip.
// The model is checked every cycle on the falling edge.
// Directed steps also check hand-computed literal values.
// Inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_spio_spinnaker_link_sync_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_v = 4'h0;
    logic       clr_v = 1'b0;

    logic [3:0]  out_a  [3];
    logic [3:0]  rise_a [3];
    logic [3:0]  fall_a [3];
    logic        chg_a  [3];
`ifdef SPIO_SYNC_GLITCH_CNT_EN
    logic [31:0] gc_a   [3];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h expected=%h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int ST = (g == 1) ? 3 : 2;
        localparam int FL = (g == 0) ? 4 : ((g == 1) ? 1 : 3);
        localparam bit RV = (g == 2) ? 1'b1 : 1'b0;

        spio_spinnaker_link_sync_filter #(
            .SIZE(4), .STAGES(ST), .FILTER(FL), .RST_VAL(RV)
        ) u_dut (
            .CLK_IN        (clk),
            .RESET_IN      (rst),
            .IN            (in_v),
            .OUT           (out_a[g]),
            .RISE_OUT      (rise_a[g]),
            .FALL_OUT      (fall_a[g]),
            .CHANGE_OUT    (chg_a[g])
`ifdef SPIO_SYNC_GLITCH_CNT_EN
            ,
            .CLR_GLITCH_IN (clr_v),
            .GLITCH_CNT_OUT(gc_a[g])
`endif
        );

        // Behavioural model state
        bit          started = 1'b0;
        logic [3:0]  dly_q [$];
        logic [3:0]  win_q [$];
        logic [3:0]  m_out, m_rise, m_fall, pend;
        logic [3:0]  s_pre, flip, glitch;
        int unsigned gcnt [4];
        logic [31:0] m_gc;

        initial begin
            forever begin
                @(posedge clk);
                if (rst) begin
                    started = 1'b1;
                    dly_q.delete();
                    for (int k = 0; k < ST; k++) dly_q.push_back({4{RV}});
                    win_q.delete();
                    m_out  = {4{RV}};
                    m_rise = '0;
                    m_fall = '0;
                    pend   = '0;
                    for (int b = 0; b < 4; b++) gcnt[b] = 0;
                end else if (started) begin
                    s_pre = dly_q.pop_front();
                    dly_q.push_back(in_v);
                    win_q.push_back(s_pre);
                    if (win_q.size() > FL) void'(win_q.pop_front());
                    flip = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (win_q.size() == FL) begin
                            flip[b] = 1'b1;
                            foreach (win_q[k]) if (win_q[k][b] == m_out[b]) flip[b] = 1'b0;
                        end
                    end
                    glitch = pend & ~(s_pre ^ m_out);
                    for (int b = 0; b < 4; b++) begin
                        if (clr_v) gcnt[b] = 0;
                        else if (glitch[b] && gcnt[b] < 255) gcnt[b]++;
                    end
                    pend   = (s_pre ^ m_out) & ~flip;
                    m_rise = flip & ~m_out;
                    m_fall = flip & m_out;
                    m_out  = m_out ^ flip;
                end
                for (int b = 0; b < 4; b++) m_gc[8*b +: 8] = 8'(gcnt[b]);
            end
        end

        // Compare process
        initial begin
            forever begin
                @(negedge clk);
                if (started) begin
                    chk("out", g, 32'(out_a[g]), 32'(m_out));
                    chk("rise", g, 32'(rise_a[g]), 32'(m_rise));
                    chk("fall", g, 32'(fall_a[g]), 32'(m_fall));
                    chk("change", g, 32'(chg_a[g]), 32'(|(m_rise | m_fall)));
`ifdef SPIO_SYNC_GLITCH_CNT_EN
                    chk("glitch_cnt", g, gc_a[g], m_gc);
`endif
                end
            end
        end
    end

    int       hold [4];
    logic [3:0] cur;

    initial begin
        // Reset for two edges
        rst = 1'b1; in_v = 4'h0; clr_v = 1'b0;
        tick(); tick();
        chk("lit_rst_out", 0, 32'(out_a[0]), 32'h0);
        chk("lit_rst_out", 2, 32'(out_a[2]), 32'hF);
        chk("lit_rst_chg", 2, 32'(chg_a[2]), 32'h0);
        chk("lit_rst_rise", 1, 32'(rise_a[1]), 32'h0);

        // Simultaneous multi-bit change 0000 -> 1010 (edge 1 samples it)
        rst = 1'b0; in_v = 4'hA;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3) chk("lit_f1_early", 1, 32'(out_a[1]), 32'h0);
            if (k == 4) begin
                chk("lit_f1_out", 1, 32'(out_a[1]), 32'hA);
                chk("lit_f1_rise", 1, 32'(rise_a[1]), 32'hA);
                chk("lit_f1_chg", 1, 32'(chg_a[1]), 32'h1);
                chk("lit_f3_hold", 2, 32'(out_a[2]), 32'hF);
            end
            if (k == 5) begin
                chk("lit_f1_rise_end", 1, 32'(rise_a[1]), 32'h0);
                chk("lit_f3_out", 2, 32'(out_a[2]), 32'hA);
                chk("lit_f3_fall", 2, 32'(fall_a[2]), 32'h5);
                chk("lit_f4_early", 0, 32'(out_a[0]), 32'h0);
            end
            if (k == 6) begin
                chk("lit_f4_out", 0, 32'(out_a[0]), 32'hA);
                chk("lit_f4_rise", 0, 32'(rise_a[0]), 32'hA);
                chk("lit_f4_chg", 0, 32'(chg_a[0]), 32'h1);
            end
            if (k == 7) begin
                chk("lit_f4_rise_end", 0, 32'(rise_a[0]), 32'h0);
                chk("lit_f4_chg_end", 0, 32'(chg_a[0]), 32'h0);
            end
        end

        // Three-cycle pulse on bit 0 must be rejected by FILTER=4
        in_v = 4'hB;
        tick(); tick(); tick();
        in_v = 4'hA;
        for (int k = 4; k <= 8; k++) tick();
        chk("lit_glitch_out", 0, 32'(out_a[0]), 32'hA);
`ifdef SPIO_SYNC_GLITCH_CNT_EN
        chk("lit_glitch_cnt", 0, 32'(gc_a[0][7:0]), 32'h1);
`endif

        // Reset in the middle of a count (dut2, RST_VAL=1)
        rst = 1'b1; tick();
        rst = 1'b0; in_v = 4'h0;
        tick(); tick(); tick(); tick();
        chk("lit_cnt2_out", 2, 32'(out_a[2]), 32'hF);
        rst = 1'b1; in_v = 4'hF; tick();
        chk("lit_midrst_out", 2, 32'(out_a[2]), 32'hF);
        chk("lit_midrst_fall", 2, 32'(fall_a[2]), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("lit_exit_out", 2, 32'(out_a[2]), 32'hF);
        chk("lit_exit_chg", 2, 32'(chg_a[2]), 32'h0);

        // 300 single-cycle glitches on bit 1, then a clear that coincides with a glitch
        rst = 1'b1; in_v = 4'h0; tick();
        rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            in_v = 4'h2; tick();
            in_v = 4'h0; tick(); tick(); tick();
        end
        chk("lit_sat_out", 0, 32'(out_a[0]), 32'h0);
`ifdef SPIO_SYNC_GLITCH_CNT_EN
        chk("lit_sat_cnt", 0, 32'(gc_a[0][15:8]), 32'hFF);
        chk("lit_sat_other", 0, 32'(gc_a[0][7:0]), 32'h0);
`endif
        in_v = 4'h2; tick();
        in_v = 4'h0; tick(); tick();
`ifdef SPIO_SYNC_GLITCH_CNT_EN
        chk("lit_sat_hold", 0, 32'(gc_a[0][15:8]), 32'hFF);
`endif
        clr_v = 1'b1; tick();
        clr_v = 1'b0;
`ifdef SPIO_SYNC_GLITCH_CNT_EN
        chk("lit_clr_wins", 0, 32'(gc_a[0][15:8]), 32'h0);
`endif

        // Random phase: per-bit random hold lengths, rare resets and clears
        for (int b = 0; b < 4; b++) hold[b] = 0;
        cur = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    cur[b]  = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 7);
                end
                hold[b]--;
            end
            in_v  = cur;
            rst   = ($urandom_range(0, 199) == 0);
            clr_v = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0; clr_v = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
